// File: rtl/fir_ctrl_pkg.sv
// Shared types and constants for the FIR gain ramp controller.
// Gain words are signed Q12.12, so unity gain is 1 << 12.
package fir_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP      = 2'd1,
    MUTE_RAMP = 2'd2,
    MUTED     = 2'd3
  } gain_state_e;

  localparam int GAIN_FRAC  = 12;
  localparam int GAIN_UNITY = 1 << GAIN_FRAC;

endpackage

// File: rtl/fir_gain_step.sv
// One clamped step of a gain value toward a target.
// A step of zero, or a remaining distance within one step, lands exactly on the target.
module fir_gain_step #(
  parameter int SAMP_WIDTH = 24,
  parameter int STEP_WIDTH = 16
) (
  input  logic signed [SAMP_WIDTH-1:0] i_cur,
  input  logic signed [SAMP_WIDTH-1:0] i_tgt,
  input  logic        [STEP_WIDTH-1:0] i_step,
  output logic signed [SAMP_WIDTH-1:0] o_nxt,
  output logic                         o_done
);

  // Compare width covers both the full-range distance and the step magnitude.
  localparam int CW = ((SAMP_WIDTH + 1 > STEP_WIDTH) ? SAMP_WIDTH + 1 : STEP_WIDTH) + 1;

  logic signed [SAMP_WIDTH:0] w_diff;
  logic        [SAMP_WIDTH:0] w_mag;

  always_comb begin
    w_diff = {i_tgt[SAMP_WIDTH-1], i_tgt} - {i_cur[SAMP_WIDTH-1], i_cur};
    w_mag  = w_diff[SAMP_WIDTH] ? $unsigned(-w_diff) : $unsigned(w_diff);
    o_done = (i_step == '0) || (CW'(w_mag) <= CW'(i_step));
    if (o_done)
      o_nxt = i_tgt;
    else if (w_diff[SAMP_WIDTH])
      o_nxt = i_cur - $signed(SAMP_WIDTH'(i_step));
    else
      o_nxt = i_cur + $signed(SAMP_WIDTH'(i_step));
  end

endmodule

// File: rtl/fir_gain_ramp_ctrl.sv
// Click-free gain sequencer for the lowpass FIR path: ramps toward a configured
// target once per sample strobe and provides a soft mute that preserves the target.
module fir_gain_ramp_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter int SAMP_WIDTH = 24,
  parameter int STEP_WIDTH = 16,
  parameter int MUTE_STEP  = 256
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_samp_stb,
  input  logic                         i_cfg_valid,
  output logic                         o_cfg_ready,
  input  logic signed [SAMP_WIDTH-1:0] i_cfg_gain,
  input  logic        [STEP_WIDTH-1:0] i_cfg_step,
  input  logic                         i_mute,
  output logic signed [SAMP_WIDTH-1:0] o_gain,
  output logic                         o_busy,
  output logic                         o_muted
);

  gain_state_e                  r_state, w_state_nxt;
  logic signed [SAMP_WIDTH-1:0] r_gain, w_gain_nxt;
  logic signed [SAMP_WIDTH-1:0] r_target, w_target_nxt;
  logic        [STEP_WIDTH-1:0] r_step, w_step_nxt;

  logic                         w_cfg_fire;
  logic signed [SAMP_WIDTH-1:0] w_step_tgt;
  logic        [STEP_WIDTH-1:0] w_step_mag;
  logic signed [SAMP_WIDTH-1:0] w_step_out;
  logic                         w_step_done;

  assign o_cfg_ready = (r_state != MUTE_RAMP);
  assign o_busy      = (r_state == RAMP) || (r_state == MUTE_RAMP);
  assign o_muted     = (r_state == MUTED);
  assign o_gain      = r_gain;
  assign w_cfg_fire  = i_cfg_valid && o_cfg_ready;

  // The single stepper is shared: mute ramps aim at zero with the fixed step.
  assign w_step_tgt = (r_state == MUTE_RAMP) ? '0 : r_target;
  assign w_step_mag = (r_state == MUTE_RAMP) ? STEP_WIDTH'(MUTE_STEP) : r_step;

  fir_gain_step #(
    .SAMP_WIDTH (SAMP_WIDTH),
    .STEP_WIDTH (STEP_WIDTH)
  ) u_step (
    .i_cur  (r_gain),
    .i_tgt  (w_step_tgt),
    .i_step (w_step_mag),
    .o_nxt  (w_step_out),
    .o_done (w_step_done)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_gain_nxt   = r_gain;
    w_target_nxt = r_target;
    w_step_nxt   = r_step;
    if (w_cfg_fire) begin
      w_target_nxt = i_cfg_gain;
      w_step_nxt   = i_cfg_step;
    end
    case (r_state)
      IDLE: begin
        if (i_mute)
          w_state_nxt = MUTE_RAMP;
        else if (w_cfg_fire && (i_cfg_gain != r_gain))
          w_state_nxt = RAMP;
      end
      RAMP: begin
        if (i_samp_stb) begin
          w_gain_nxt = w_step_out;
          // A landing step must not strand a target that arrived on the same cycle.
          if (w_step_done && !(w_cfg_fire && (i_cfg_gain != w_step_out)))
            w_state_nxt = IDLE;
        end
        if (i_mute)
          w_state_nxt = MUTE_RAMP;
      end
      MUTE_RAMP: begin
        if (!i_mute)
          w_state_nxt = RAMP;
        else if (i_samp_stb) begin
          w_gain_nxt = w_step_out;
          if (w_step_done)
            w_state_nxt = MUTED;
        end
      end
      MUTED: begin
        if (!i_mute)
          w_state_nxt = RAMP;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_gain   <= SAMP_WIDTH'(GAIN_UNITY);
      r_target <= SAMP_WIDTH'(GAIN_UNITY);
      r_step   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_gain   <= w_gain_nxt;
      r_target <= w_target_nxt;
      r_step   <= w_step_nxt;
    end
  end

endmodule
